// File: rtl/rr_packet_arbiter_if.sv
// Handshake bundle between the input ports, the arbiter and the downstream link.
// The master side drives requests, tails and credit returns; the slave side is the arbiter.
interface rr_packet_arbiter_if #(
    parameter int CW = 3
) ();
    logic [4:0]    req;
    logic [4:0]    tail;
    logic          credit_in;
    logic [4:0]    grant;
    logic [4:0]    xbar_sel;
    logic          valid_out;
    logic [CW-1:0] credit_cnt;
    logic          credit_err;

    modport master (
        output req, tail, credit_in,
        input  grant, xbar_sel, valid_out, credit_cnt, credit_err
    );

    modport slave (
        input  req, tail, credit_in,
        output grant, xbar_sel, valid_out, credit_cnt, credit_err
    );
endinterface

// File: rtl/rr_packet_arbiter.sv
// Round-robin, packet-locked output-port arbiter for a 5-port mesh router (L,N,E,W,S)
// with credit-based flow control toward the downstream input buffer.
module rr_packet_arbiter #(
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input logic                clk,
    input logic                rst,
    rr_packet_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);

    state_t        state_q, state_d;
    logic [2:0]    owner_q, owner_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          err_q, err_d;

    logic [4:0]    owner_oh_s;
    logic [4:0]    grant_s;
    logic          valid_s;
    logic [2:0]    winner_s;
    logic [2:0]    idx_s;
    logic          found_s;

    function automatic logic [4:0] onehot5(input logic [2:0] idx);
        logic [4:0] oh;
        case (idx)
            3'd0:    oh = 5'b00001;
            3'd1:    oh = 5'b00010;
            3'd2:    oh = 5'b00100;
            3'd3:    oh = 5'b01000;
            3'd4:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    function automatic logic [2:0] inc_mod5(input logic [2:0] v);
        logic [2:0] r;
        if (v >= 3'd4) begin
            r = 3'd0;
        end else begin
            r = v + 3'd1;
        end
        return r;
    endfunction

    assign owner_oh_s = onehot5(owner_q);

    // Round-robin search: first requesting port at or after ptr, wrapping mod 5
    always_comb begin
        winner_s = ptr_q;
        found_s  = 1'b0;
        idx_s    = ptr_q;
        for (int k = 0; k < 5; k++) begin
            if (!found_s && (|(bus.req & onehot5(idx_s)))) begin
                winner_s = idx_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
            idx_s = inc_mod5(idx_s);
        end
    end

    // Packet-lock FSM: arbitrate in IDLE, hold the owner until its tail flit is granted
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_s = 5'b00000;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    owner_d = winner_s;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if ((|(bus.req & owner_oh_s)) && (credit_q != {CW{1'b0}})) begin
                    grant_s = owner_oh_s;
                    if (|(bus.tail & owner_oh_s)) begin
                        state_d = IDLE;
                        ptr_d   = inc_mod5(owner_q);
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    grant_s = 5'b00000;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign valid_s = |grant_s;

    // Credit counter; a return at full count is a protocol error and leaves the count alone
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (valid_s && !bus.credit_in) begin
            credit_d = credit_q - CRED_ONE;
        end else if (!valid_s && bus.credit_in) begin
            if (credit_q >= CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + CRED_ONE;
            end
        end else begin
            credit_d = credit_q;
        end
    end

    // State, owner, pointer and credit registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 3'd0;
            ptr_q    <= 3'd0;
            credit_q <= CRED_MAX;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign bus.grant      = grant_s;
    assign bus.valid_out  = valid_s;
    assign bus.xbar_sel   = (state_q == BUSY) ? owner_oh_s : 5'b00000;
    assign bus.credit_cnt = credit_q;
    assign bus.credit_err = err_q;
endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter: inputs change 1 time unit after the rising edge,
// outputs are compared on the falling edge against hand-computed values.
module tb_rr_packet_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rr_packet_arbiter_if #(.CW(3)) bus ();

    rr_packet_arbiter #(.CREDITS(4), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic c);
        bus.req       = r;
        bus.tail      = t;
        bus.credit_in = c;
        @(negedge clk);
    endtask

    logic [4:0] oh;

    initial begin
        bus.req = 5'b00000; bus.tail = 5'b00000; bus.credit_in = 1'b0;
        nxt(); nxt();
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 4; i++) begin
            drive(5'b00000, 5'b00000, 1'b0);
            chk("rst_grant", 32'(bus.grant), 32'h0);
            chk("rst_xbar", 32'(bus.xbar_sel), 32'h0);
            chk("rst_cnt", 32'(bus.credit_cnt), 32'd4);
            chk("rst_err", 32'(bus.credit_err), 32'h0);
            nxt();
        end

        // all ports request, 2-flit packets, credit returned with each grant
        for (int p = 0; p < 6; p++) begin
            oh = 5'b00001 << (p % 5);
            drive(5'b11111, 5'b00000, 1'b0);
            chk("rr_gap", 32'(bus.grant), 32'h0);
            chk("rr_gap_xbar", 32'(bus.xbar_sel), 32'h0);
            nxt();
            drive(5'b11111, 5'b00000, 1'b1);
            chk("rr_flit1", 32'(bus.grant), 32'(oh));
            chk("rr_xbar", 32'(bus.xbar_sel), 32'(oh));
            chk("rr_valid", 32'(bus.valid_out), 32'h1);
            nxt();
            drive(5'b11111, 5'b11111, 1'b1);
            chk("rr_flit2", 32'(bus.grant), 32'(oh));
            nxt();
        end
        chk("rr_cnt", 32'(bus.credit_cnt), 32'd4);

        // E alone, 6-flit packet, credits run out (ptr=N, search reaches E)
        drive(5'b00100, 5'b00000, 1'b0);
        chk("e_arb", 32'(bus.grant), 32'h0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            drive(5'b00100, 5'b00000, 1'b0);
            chk("e_grant", 32'(bus.grant), 32'h04);
            chk("e_cnt", 32'(bus.credit_cnt), 32'(4 - i));
            nxt();
        end
        for (int i = 0; i < 2; i++) begin
            drive(5'b00100, 5'b00000, 1'b0);
            chk("e_stall", 32'(bus.grant), 32'h0);
            chk("e_stall_xbar", 32'(bus.xbar_sel), 32'h04);
            chk("e_stall_cnt", 32'(bus.credit_cnt), 32'd0);
            nxt();
        end
        drive(5'b00100, 5'b00000, 1'b1);
        chk("e_ret_nogrant", 32'(bus.grant), 32'h0);
        nxt();
        drive(5'b00100, 5'b00000, 1'b0);
        chk("e_flit5", 32'(bus.grant), 32'h04);
        chk("e_flit5_cnt", 32'(bus.credit_cnt), 32'd1);
        nxt();
        drive(5'b00100, 5'b00000, 1'b1);
        chk("e_ret2_nogrant", 32'(bus.grant), 32'h0);
        nxt();
        drive(5'b00100, 5'b00100, 1'b0);
        chk("e_tail", 32'(bus.grant), 32'h04);
        nxt();
        for (int i = 0; i < 4; i++) begin
            drive(5'b00000, 5'b00000, 1'b1);
            nxt();
        end
        chk("refill_cnt", 32'(bus.credit_cnt), 32'd4);
        chk("refill_err", 32'(bus.credit_err), 32'h0);

        // N packet with L and S waiting; N stalls mid-packet (ptr=W, search reaches N)
        drive(5'b00010, 5'b00000, 1'b0);
        nxt();
        drive(5'b00010, 5'b00000, 1'b1);
        chk("n_flit1", 32'(bus.grant), 32'h02);
        nxt();
        drive(5'b10011, 5'b00000, 1'b1);
        chk("n_flit2", 32'(bus.grant), 32'h02);
        nxt();
        for (int i = 0; i < 3; i++) begin
            drive(5'b10001, 5'b00000, 1'b0);
            chk("n_lock_grant", 32'(bus.grant), 32'h0);
            chk("n_lock_xbar", 32'(bus.xbar_sel), 32'h02);
            nxt();
        end
        drive(5'b10011, 5'b00010, 1'b1);
        chk("n_tail", 32'(bus.grant), 32'h02);
        nxt();
        // ptr=E after N's tail: search order E,W,S,L,N reaches S before L
        drive(5'b10001, 5'b00000, 1'b0);
        chk("ls_gap", 32'(bus.grant), 32'h0);
        nxt();
        drive(5'b10001, 5'b10000, 1'b1);
        chk("s_win", 32'(bus.grant), 32'h10);
        nxt();
        drive(5'b00001, 5'b00000, 1'b0);
        chk("l_gap", 32'(bus.grant), 32'h0);
        nxt();
        drive(5'b00001, 5'b00001, 1'b1);
        chk("l_win", 32'(bus.grant), 32'h01);
        nxt();

        // credit return at full count is an error, sticky
        drive(5'b00000, 5'b00000, 1'b1);
        chk("ovf_cnt_pre", 32'(bus.credit_cnt), 32'd4);
        nxt();
        drive(5'b00000, 5'b00000, 1'b0);
        chk("ovf_cnt", 32'(bus.credit_cnt), 32'd4);
        chk("ovf_err", 32'(bus.credit_err), 32'h1);
        nxt();
        drive(5'b00001, 5'b00000, 1'b0);
        chk("ovf_err_sticky", 32'(bus.credit_err), 32'h1);
        nxt();
        drive(5'b00001, 5'b00001, 1'b1);
        chk("gc_grant", 32'(bus.grant), 32'h01);
        nxt();
        drive(5'b00000, 5'b00000, 1'b0);
        chk("gc_cnt", 32'(bus.credit_cnt), 32'd4);
        chk("gc_err", 32'(bus.credit_err), 32'h1);
        nxt();

        // reset in BUSY with one credit left
        drive(5'b00001, 5'b00000, 1'b0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            drive(5'b00001, 5'b00000, 1'b0);
            chk("pre_rst_grant", 32'(bus.grant), 32'h01);
            nxt();
        end
        drive(5'b00001, 5'b00000, 1'b0);
        chk("pre_rst_cnt", 32'(bus.credit_cnt), 32'd1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        drive(5'b11111, 5'b00000, 1'b0);
        chk("post_rst_grant", 32'(bus.grant), 32'h0);
        chk("post_rst_xbar", 32'(bus.xbar_sel), 32'h0);
        chk("post_rst_cnt", 32'(bus.credit_cnt), 32'd4);
        chk("post_rst_err", 32'(bus.credit_err), 32'h0);
        nxt();
        // ptr back at L
        drive(5'b11111, 5'b00000, 1'b0);
        chk("post_rst_ptr", 32'(bus.grant), 32'h01);
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
